instr_fill_responder: RTL

System-side responder for the fetch stage's instruction-request interface: accepts PC requests from fetch, queues them, reads the instruction word from a synchronous instruction RAM after a programmable number of wait states, and returns the PC and instruction to fetch under a valid/ready handshake. It replaces the fixed zero-latency instruction source so fetch can be exercised against slow memory. Its `busy` output feeds the global stall (`AnyStall`) in the top level, and a redirect from execute drives its `flush` input.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fill_req_fifo.sv | 53 +++++
 rtl/instr_fill_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared widths, limits and state type for the instruction fill responder.
package mips_pkg;

  localparam int unsigned PC_W         = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned FILL_LAT_MAX = 15;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    DATA,
    RESP
  } fill_state_t;

endpackage

// File: rtl/fill_req_fifo.sv
// Request FIFO for the fill responder: show-ahead read, synchronous clear,
// extra pointer bit to tell full from empty.
module fill_req_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_idx;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A push coinciding with clear lands in slot 0 so it survives the clear.
  always_comb begin
    wr_idx = wr_ptr[AW-1:0];
    if (clear) wr_idx = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_ONE : '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && (clear || !full)) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/instr_fill_responder.sv
// Instruction fill responder: queues fetch PCs, reads a synchronous RAM after
// LATENCY wait states and returns PC + instruction under valid/ready.
module instr_fill_responder
  import mips_pkg::*;
#(
  parameter int unsigned LATENCY = 0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  input  logic [PC_W-1:0]    req_pc,
  output logic               req_ready,
  output logic               fill_valid,
  input  logic               fill_ready,
  output logic [PC_W-1:0]    fill_pc,
  output logic [INSTR_W-1:0] fill_instr,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               busy
);

  localparam int unsigned      CNT_W       = $clog2(FILL_LAT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_INIT    = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;
  localparam fill_state_t      START_STATE = (LATENCY == 0) ? READ : WAIT;

  fill_state_t      state;
  fill_state_t      state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [PC_W-1:0]  cur_pc;
  logic [PC_W-1:0]  fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic             ready_q;

  // ready_q keeps req_ready low while reset is held and for no longer.
  assign req_ready  = ready_q && !fifo_full;
  assign busy       = !req_ready;
  assign push       = req_valid && req_ready;
  assign fill_valid = (state == RESP);
  assign mem_en     = (state == READ);
  assign mem_addr   = mem_en ? cur_pc[ADDR_W+1:2] : '0;

  fill_req_fifo #(
    .WIDTH(PC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clear(flush),
    .push (push),
    .pop  (pop),
    .din  (req_pc),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    pop        = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START_STATE;
          count_next = LAT_INIT;
        end
      end
      WAIT: begin
        if (count <= CNT_ONE) state_next = READ;
        else                  count_next = count - CNT_ONE;
      end
      READ: state_next = DATA;
      DATA: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (fill_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START_STATE;
            count_next = LAT_INIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Redirect abandons whatever is in flight, including a pending RAM word.
    if (flush) begin
      state_next = IDLE;
      pop        = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      cur_pc     <= '0;
      fill_pc    <= '0;
      fill_instr <= '0;
      ready_q    <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ready_q <= 1'b1;
      if (pop) cur_pc <= fifo_dout;
      if (capture) begin
        fill_pc    <= cur_pc;
        fill_instr <= mem_rdata;
      end
    end
  end

endmodule
